pwm_decoder: RTL and testbench
==============================

// Module: pwm_decoder
// PURPOSE
//  Receive-side counterpart of the 10-bit PWM DAC: samples an asynchronous PWM
//  waveform, measures high time per frame (frame = rising edge to rising edge)
//  and recovers the original data word. Sits on the input side of a board link
//  or in a loopback bench against pwm, with one word plus valid strobe per frame.
// PARAMETERS
//  WIDTH        10  data width; nominal frame period is 2**WIDTH clk cycles
//  SYNC_STAGES  2   flip-flop stages in the pwm_in synchroniser (>=2)
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  rst_n       in   1      asynchronous, active-low reset
//  pwm_in      in   1      PWM waveform, asynchronous to clk
//  data_out    out  WIDTH  recovered word, held until next publish
//  valid       out  1      one-cycle pulse when data_out updates
//  period_err  out  1      set at publish if measured period != 2**WIDTH
//  lost        out  1      high while no rising edge seen for 2**WIDTH low cycles
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, counters 0, data_out=0,
//    valid=0, period_err=0, lost=0. Reset mid-frame abandons the frame; no publish.
//  - pwm_in passes SYNC_STAGES flops; s = synchronised level, rise = s & ~s_d.
//  - Counters hi_cnt, per_cnt are WIDTH+1 bits, saturate at 2**WIDTH.
//  - States: IDLE, HIGH, LOW.
//    IDLE: wait for rise; on rise -> HIGH, hi_cnt=1, per_cnt=1, lost=0.
//    HIGH: s=1 -> hi_cnt++, per_cnt++; s=0 -> LOW, per_cnt++.
//      hi_cnt reaching 2**WIDTH with s still 1 (constant high): publish
//      data_out=2**WIDTH-1, period_err=0, reload hi_cnt=1, per_cnt=1, stay HIGH.
//    LOW: rise -> publish data_out=hi_cnt-1, period_err=(per_cnt!=2**WIDTH),
//      reload hi_cnt=1, per_cnt=1, -> HIGH. Otherwise per_cnt++; low run of
//      2**WIDTH cycles without rise -> lost=1, -> IDLE, data_out held, no valid.
//  - Publish = register data_out/period_err and pulse valid for exactly 1 cycle.
//  - Latency: valid rises SYNC_STAGES+1 clk edges after the first edge sampling
//    the new frame's pwm_in high.
//  - Mapping vs encoder (high for d+1 of 1024 cycles): data_out = d exactly;
//    d=1023 (constant high) reports 1023 every 1024 cycles via saturation path.
//  - Mid-frame data change / short frames: report measured value, flag period_err.
//  - Frame shorter than 2 cycles impossible (rise requires prior low); no special case.
// STRUCTURE
//  - Package pwm_pkg: PWM_WIDTH=10, PWM_PERIOD=2**PWM_WIDTH, decoder state enum
//    {IDLE,HIGH,LOW}; shared with pwm encoder bench.
//  - Sub-module sync_edge: SYNC_STAGES synchroniser + registered rising-edge
//    detect, outputs s and rise. Remainder (FSM, counters, output regs) in top.
// TESTING
//  - Reset with pwm_in=0 for 3000 cycles -> valid never pulses, lost=1 after
//    1024 low cycles (plus sync delay), data_out=0.
//  - Loopback pwm encoder, load d=0,1,512,1022 -> each valid frame after first
//    full frame shows data_out=d, period_err=0.
//  - Loopback d=1023 (constant high) -> valid every 1024 cycles, data_out=1023.
//  - Direct stimulus: 100 high / 200 low frames -> data_out=99, period_err=1.
//  - Assert rst_n low mid-HIGH with hi_cnt=300 -> outputs 0 immediately, no
//    valid until next complete rise-to-rise frame.
//  - pwm_in low >1024 cycles then resume d=700 -> lost=1, clears on first
//    rise, next publish data_out=700, lost=0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM link definitions: frame geometry and the decoder state set.
// Also imported by the PWM encoder bench.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH  = 10;
    localparam int unsigned PWM_PERIOD = 2 ** PWM_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } dec_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous level, with rising-edge detect
// taken from the synchronised output and its one-cycle-delayed copy.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

endmodule

// File: rtl/pwm_decoder.sv
// PWM receiver: measures high time and period of each rise-to-rise frame of
// the synchronised input and publishes the recovered word with a valid strobe.
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH       = PWM_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             period_err,
    output logic             lost
);

    localparam int unsigned   CW   = WIDTH + 1;
    localparam logic [CW-1:0] FULL = {1'b1, {WIDTH{1'b0}}};
    localparam logic [CW-1:0] ONE  = CW'(1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == FULL) ? v : v + ONE;
    endfunction

    logic          s;
    logic          rise;
    dec_state_e    state;
    dec_state_e    state_d;
    logic [CW-1:0] hi_cnt;
    logic [CW-1:0] per_cnt;
    logic [CW-1:0] lo_cnt;
    logic          lo_full;
    logic          start;
    logic          pub_rise;
    logic          pub_sat;
    logic          hi_inc;
    logic          per_inc;
    logic          set_lost;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (pwm_in),
        .s    (s),
        .rise (rise)
    );

    // lo_cnt is a plain run length of s low, independent of the FSM; it only
    // matters in IDLE and LOW, where it drives the loss-of-signal flag.
    assign lo_full = ~s && (sat_inc(lo_cnt) == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (!s) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (lo_full) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start    = 1'b0;
        pub_rise = 1'b0;
        pub_sat  = 1'b0;
        hi_inc   = 1'b0;
        per_inc  = 1'b0;
        set_lost = 1'b0;
        unique case (state)
            IDLE: begin
                start    = rise;
                set_lost = lo_full;
            end
            HIGH: begin
                if (s) begin
                    // A constant-high input never produces a rise, so a full
                    // count of high cycles closes the frame as the maximum word.
                    if (hi_cnt == FULL) begin
                        pub_sat = 1'b1;
                    end else begin
                        hi_inc  = 1'b1;
                        per_inc = 1'b1;
                    end
                end else begin
                    per_inc = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    pub_rise = 1'b1;
                    start    = 1'b1;
                end else begin
                    per_inc  = 1'b1;
                    set_lost = lo_full;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt  <= '0;
            per_cnt <= '0;
            lo_cnt  <= '0;
        end else begin
            lo_cnt <= s ? '0 : sat_inc(lo_cnt);
            if (start || pub_sat) begin
                hi_cnt  <= ONE;
                per_cnt <= ONE;
            end else begin
                if (hi_inc) begin
                    hi_cnt <= sat_inc(hi_cnt);
                end
                if (per_inc) begin
                    per_cnt <= sat_inc(per_cnt);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            valid      <= 1'b0;
            period_err <= 1'b0;
            lost       <= 1'b0;
        end else begin
            valid <= pub_rise | pub_sat;
            if (pub_sat) begin
                data_out   <= '1;
                period_err <= 1'b0;
            end else if (pub_rise) begin
                data_out   <= WIDTH'(hi_cnt - ONE);
                period_err <= (per_cnt != FULL);
            end
            if (start) begin
                lost <= 1'b0;
            end else if (set_lost) begin
                lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: frame-level stimulus, expected publishes queued from
// frame geometry and compared whenever valid pulses.
module tb_pwm_decoder;
    import pwm_pkg::*;

    localparam int unsigned W    = PWM_WIDTH;
    localparam int unsigned PER  = PWM_PERIOD;
    localparam int unsigned SYNC = 2;
    localparam int unsigned LAT  = SYNC + 1;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         pwm_in = 1'b0;
    logic [W-1:0] data_out;
    logic         valid;
    logic         period_err;
    logic         lost;

    always #5 clk = ~clk;

    pwm_decoder #(
        .WIDTH      (W),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .data_out  (data_out),
        .valid     (valid),
        .period_err(period_err),
        .lost      (lost)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         e;
        bit           sat;
        longint       rise_p;
    } exp_t;

    typedef struct {
        int unsigned  hi;
        int unsigned  lo;
        logic [W-1:0] d;
        logic         e;
    } vec_t;

    int unsigned  n_cmp = 0;
    int unsigned  n_bad = 0;
    exp_t         expq[$];
    longint       pcyc = 0;
    longint       last_valid_p = 0;
    bit           have_pend = 1'b0;
    logic [W-1:0] pend_d = '0;
    logic         pend_e = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) pcyc <= pcyc + 1;

    always @(negedge clk) begin : monitor
        exp_t x;
        if (rst_n && valid) begin
            if (expq.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                x = expq.pop_front();
                check("data_out", longint'(data_out), longint'(x.d));
                check("period_err", longint'(period_err), longint'(x.e));
                if (x.sat) check("sat_interval", pcyc - last_valid_p, PER);
                else       check("latency", pcyc - x.rise_p, LAT);
            end
            last_valid_p = pcyc;
        end
    end

    // Expected outcome of one frame of h high / l low cycles, from the link rules:
    // each full run of PER high cycles past the first reports max, the remainder is
    // the word; the period measurement saturates at PER.
    function automatic void ref_frame(input int unsigned h, input int unsigned l,
                                      output int unsigned nsat, output logic [W-1:0] d,
                                      output logic e, output bit lst);
        int unsigned tail;
        int unsigned per;
        nsat = (h - 1) / PER;
        tail = h - nsat * PER;
        d    = W'(tail - 1);
        per  = tail + l;
        if (per > PER) per = PER;
        e    = (per != PER);
        lst  = (l >= PER);
    endfunction

    task automatic rise_now();
        pwm_in = 1'b1;
        if (have_pend) expq.push_back('{d: pend_d, e: pend_e, sat: 1'b0, rise_p: pcyc});
        have_pend = 1'b0;
    endtask

    // Entered and left at posedge+2; pwm_in is sampled high for h edges, low for l.
    task automatic drive_frame(input int unsigned h, input int unsigned l, input int unsigned nsat,
                               input logic [W-1:0] d, input logic e, input bit lst);
        rise_now();
        for (int unsigned i = 0; i < nsat; i++)
            expq.push_back('{d: {W{1'b1}}, e: 1'b0, sat: 1'b1, rise_p: 0});
        for (int unsigned i = 0; i < h; i++) begin
            @(posedge clk);
            if (i == 3) begin
                #1;
                check("lost_clear", longint'(lost), 0);
            end
        end
        #2 pwm_in = 1'b0;
        repeat (l) @(posedge clk);
        #2;
        if (lst) begin
            if (l >= PER + SYNC + 1) check("lost_set", longint'(lost), 1);
            have_pend = 1'b0;
        end else begin
            have_pend = 1'b1;
            pend_d    = d;
            pend_e    = e;
        end
    endtask

    task automatic model_frame(input int unsigned h, input int unsigned l);
        int unsigned  nsat;
        logic [W-1:0] d;
        logic         e;
        bit           lst;
        ref_frame(h, l, nsat, d, e, lst);
        drive_frame(h, l, nsat, d, e, lst);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d publishes pending, expected 0", expq.size());
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        tbl[8];
        int unsigned d;
        int unsigned l;

        tbl[0] = '{hi: 1,    lo: 1023, d: 10'd0,    e: 1'b0};
        tbl[1] = '{hi: 2,    lo: 1022, d: 10'd1,    e: 1'b0};
        tbl[2] = '{hi: 513,  lo: 511,  d: 10'd512,  e: 1'b0};
        tbl[3] = '{hi: 1023, lo: 1,    d: 10'd1022, e: 1'b0};
        tbl[4] = '{hi: 100,  lo: 200,  d: 10'd99,   e: 1'b1};
        tbl[5] = '{hi: 1,    lo: 1,    d: 10'd0,    e: 1'b1};
        tbl[6] = '{hi: 300,  lo: 100,  d: 10'd299,  e: 1'b1};
        tbl[7] = '{hi: 1000, lo: 24,   d: 10'd999,  e: 1'b0};

        // Reset, then a long idle-low line.
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("rst_data_out", longint'(data_out), 0);
        check("rst_valid", longint'(valid), 0);
        check("rst_period_err", longint'(period_err), 0);
        check("rst_lost", longint'(lost), 0);
        repeat (1020) @(posedge clk);
        #1 check("lost_before_timeout", longint'(lost), 0);
        repeat (10) @(posedge clk);
        #1 check("lost_after_timeout", longint'(lost), 1);
        repeat (1970) @(posedge clk);
        #1;
        check("idle_lost_held", longint'(lost), 1);
        check("idle_data_out", longint'(data_out), 0);
        @(posedge clk);
        #2;

        for (int unsigned i = 0; i < 8; i++)
            drive_frame(tbl[i].hi, tbl[i].lo, 0, tbl[i].d, tbl[i].e, 1'b0);

        // Constant high across three full periods, then a nominal tail frame.
        model_frame(3 * PER + 512, 512);

        // Loss of signal, then recovery with a nominal frame.
        model_frame(200, 1100);
        drive_frame(701, 323, 0, 10'd700, 1'b0, 1'b0);

        // Reset in the middle of a high phase.
        rise_now();
        repeat (302) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_data_out", longint'(data_out), 0);
        check("midrst_valid", longint'(valid), 0);
        check("midrst_period_err", longint'(period_err), 0);
        check("midrst_lost", longint'(lost), 0);
        check("midrst_pending", longint'(expq.size()), 0);
        pwm_in    = 1'b0;
        have_pend = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #2;

        for (int unsigned i = 0; i < 15; i++) begin
            d = $urandom_range(0, 1022);
            if ($urandom_range(0, 9) < 7) l = 1023 - d;
            else                          l = $urandom_range(1, 1023 - d);
            model_frame(d + 1, l);
        end

        // Closing rise publishes the last frame.
        rise_now();
        repeat (LAT + 5) @(posedge clk);
        #2 pwm_in = 1'b0;
        check("queue_drained", longint'(expq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
